// File: rtl/datamem_pkg.sv
// Shared types and helpers for the split-capable byte-addressed data memory.
package datamem_pkg;

    typedef enum logic [2:0] {
        RF_LB  = 3'd0,
        RF_LH  = 3'd1,
        RF_LW  = 3'd2,
        RF_LBU = 3'd4,
        RF_LHU = 3'd5
    } read_flag_e;

    typedef enum logic [1:0] {
        WF_SB = 2'd0,
        WF_SH = 2'd1,
        WF_SW = 2'd2
    } write_flag_e;

    typedef enum logic {
        IDLE  = 1'b0,
        BEAT2 = 1'b1
    } state_e;

    // Access size in bytes (1, 2 or 4); 0 marks an illegal flag encoding.
    function automatic logic [2:0] access_size(input logic       is_write,
                                               input logic [2:0] read_flags,
                                               input logic [1:0] write_flags);
        access_size = 3'd0;
        if (is_write) begin
            case (write_flags)
                WF_SB:   access_size = 3'd1;
                WF_SH:   access_size = 3'd2;
                WF_SW:   access_size = 3'd4;
                default: access_size = 3'd0;
            endcase
        end else begin
            case (read_flags)
                RF_LB, RF_LBU: access_size = 3'd1;
                RF_LH, RF_LHU: access_size = 3'd2;
                RF_LW:         access_size = 3'd4;
                default:       access_size = 3'd0;
            endcase
        end
    endfunction

    function automatic logic is_unsigned_load(input logic [2:0] read_flags);
        return (read_flags == RF_LBU) || (read_flags == RF_LHU);
    endfunction

endpackage

// File: rtl/datamem_format.sv
// Per-beat byte steering: maps access-order bytes onto word lanes for stores,
// and gathers, orders and extends lane bytes for loads.
module datamem_format
    import datamem_pkg::*;
#(
    parameter bit LITTLE = 1'b1
) (
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_size,
    input  logic        i_beat2,
    input  logic        i_unsigned,
    input  logic [31:0] i_mem_word,
    input  logic [31:0] i_part_bytes,
    input  logic [31:0] i_store_value,
    output logic [31:0] o_acc_bytes,
    output logic [31:0] o_load_value,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_lane_data
);

    logic [2:0]  w_span;
    logic [2:0]  w_first;
    logic [3:0]  w_in_beat;
    logic [1:0]  w_lane [4];
    logic [1:0]  w_rev  [4];
    logic [7:0]  w_sbyte [4];
    logic [31:0] w_raw;

    // Bytes handled by beat 1: everything up to the end of the first word.
    assign w_span  = {1'b0, i_offset} + i_size;
    assign w_first = (w_span > 3'd4) ? (3'd4 - {1'b0, i_offset}) : i_size;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            // NOTE: every combinational output gets a default before any branch so no latch is inferred.
            w_in_beat[k] = 1'b0;
            w_lane[k]    = 2'd0;
            w_rev[k]     = 2'(i_size - 3'd1 - 3'(k));
            if (!i_beat2) begin
                w_in_beat[k] = (3'(k) < w_first);
                w_lane[k]    = 2'({1'b0, i_offset} + 3'(k));
            end else begin
                w_in_beat[k] = (3'(k) >= w_first) && (3'(k) < i_size);
                w_lane[k]    = 2'(3'(k) - w_first);
            end
            w_sbyte[k] = LITTLE ? i_store_value[8*k +: 8] : i_store_value[{w_rev[k], 3'b000} +: 8];
        end
    end

    always_comb begin
        o_acc_bytes = i_part_bytes;
        o_byte_en   = 4'b0000;
        o_lane_data = 32'd0;
        for (int k = 0; k < 4; k++) begin
            if (w_in_beat[k]) begin
                o_acc_bytes[8*k +: 8]                 = i_mem_word[{w_lane[k], 3'b000} +: 8];
                o_byte_en[w_lane[k]]                  = 1'b1;
                o_lane_data[{w_lane[k], 3'b000} +: 8] = w_sbyte[k];
            end
        end

        // Access-order byte 0 is the lowest address: LSB for LE, MSB for BE.
        w_raw = 32'd0;
        case (i_size)
            3'd1:    w_raw = {24'd0, o_acc_bytes[7:0]};
            3'd2:    w_raw = LITTLE ? {16'd0, o_acc_bytes[15:8], o_acc_bytes[7:0]}
                                    : {16'd0, o_acc_bytes[7:0], o_acc_bytes[15:8]};
            default: w_raw = LITTLE ? o_acc_bytes
                                    : {o_acc_bytes[7:0], o_acc_bytes[15:8],
                                       o_acc_bytes[23:16], o_acc_bytes[31:24]};
        endcase

        o_load_value = w_raw;
        if (!i_unsigned) begin
            case (i_size)
                3'd1:    o_load_value = {{24{w_raw[7]}}, w_raw[7:0]};
                3'd2:    o_load_value = {{16{w_raw[15]}}, w_raw[15:0]};
                default: o_load_value = w_raw;
            endcase
        end
    end

endmodule

// File: rtl/datamem_split.sv
// Byte-addressed load/store memory with valid/ready requests, registered
// responses and optional two-beat handling of word-crossing accesses.
module datamem_split
    import datamem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int ENDIANNESS  = 1,
    parameter int MISALIGNED  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [31:0] reqAddress,
    input  logic [2:0]  reqReadFlags,
    input  logic [1:0]  reqWriteFlags,
    input  logic [31:0] reqWriteValue,
    output logic        respValid,
    output logic [31:0] respValue,
    output logic        respError
);

    localparam int WORDS    = DEPTH_BYTES / 4;
    localparam int AW       = $clog2(WORDS);
    localparam bit LITTLE   = (ENDIANNESS != 0);
    localparam bit SPLIT_EN = (MISALIGNED != 0);

    logic [31:0]   r_mem [WORDS];
    state_e        r_state;
    logic          r_ready;
    logic          r_resp_valid;
    logic          r_resp_error;
    logic [31:0]   r_resp_value;
    logic [AW-1:0] r_word;
    logic [1:0]    r_offset;
    logic [2:0]    r_size;
    logic          r_unsigned;
    logic          r_write;
    logic [31:0]   r_wdata;
    logic [31:0]   r_part;

    logic [2:0]    w_size;
    logic [32:0]   w_end;
    logic          w_cross;
    logic          w_error;
    logic          w_accept;
    logic          w_beat2;
    logic [AW-1:0] w_word;
    logic [31:0]   w_mem_word;
    logic          w_mem_write;
    logic [31:0]   w_acc_bytes;
    logic [31:0]   w_load_value;
    logic [3:0]    w_byte_en;
    logic [31:0]   w_lane_data;

    assign w_size   = access_size(reqWrite, reqReadFlags, reqWriteFlags);
    // 33-bit sum so addresses near 2^32 cannot wrap into range.
    assign w_end    = {1'b0, reqAddress} + {30'd0, w_size};
    assign w_cross  = ({1'b0, reqAddress[1:0]} + w_size) > 3'd4;
    assign w_error  = (w_size == 3'd0) || (w_end > 33'(DEPTH_BYTES)) || (w_cross && !SPLIT_EN);
    assign w_accept = reqValid && r_ready;
    assign w_beat2  = (r_state == BEAT2);
    assign w_word   = w_beat2 ? AW'(r_word + 1'b1) : reqAddress[2 +: AW];

    assign w_mem_word  = r_mem[w_word];
    assign w_mem_write = (w_accept && !w_error && reqWrite) || (w_beat2 && r_write);

    datamem_format #(.LITTLE(LITTLE)) u_format (
        .i_offset      (w_beat2 ? r_offset : reqAddress[1:0]),
        .i_size        (w_beat2 ? r_size : w_size),
        .i_beat2       (w_beat2),
        .i_unsigned    (w_beat2 ? r_unsigned : is_unsigned_load(reqReadFlags)),
        .i_mem_word    (w_mem_word),
        .i_part_bytes  (r_part),
        .i_store_value (w_beat2 ? r_wdata : reqWriteValue),
        .o_acc_bytes   (w_acc_bytes),
        .o_load_value  (w_load_value),
        .o_byte_en     (w_byte_en),
        .o_lane_data   (w_lane_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the array is reset explicitly because cleared memory is part of the contract, so it maps to flops, not RAM.
            for (int i = 0; i < WORDS; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_mem_write) begin
            for (int j = 0; j < 4; j++) begin
                if (w_byte_en[j]) begin
                    r_mem[w_word][8*j +: 8] <= w_lane_data[8*j +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_value <= 32'd0;
            r_word       <= '0;
            r_offset     <= 2'd0;
            r_size       <= 3'd0;
            r_unsigned   <= 1'b0;
            r_write      <= 1'b0;
            r_wdata      <= 32'd0;
            r_part       <= 32'd0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_value <= 32'd0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_error) begin
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                        end else if (w_cross) begin
                            r_state    <= BEAT2;
                            r_ready    <= 1'b0;
                            r_word     <= reqAddress[2 +: AW];
                            r_offset   <= reqAddress[1:0];
                            r_size     <= w_size;
                            r_unsigned <= is_unsigned_load(reqReadFlags);
                            r_write    <= reqWrite;
                            r_wdata    <= reqWriteValue;
                            r_part     <= w_acc_bytes;
                        end else begin
                            r_resp_valid <= 1'b1;
                            r_resp_value <= reqWrite ? 32'd0 : w_load_value;
                        end
                    end
                end
                BEAT2: begin
                    r_state      <= IDLE;
                    r_ready      <= 1'b1;
                    r_resp_valid <= 1'b1;
                    r_resp_value <= r_write ? 32'd0 : w_load_value;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign reqReady  = r_ready;
    assign respValid = r_resp_valid;
    assign respValue = r_resp_value;
    assign respError = r_resp_error;

endmodule
